isram: RTL and testbench

ISRAM -- requirements
Module: isram

---
 rtl/isram.sv | 134 +++++++++++++
 tb/tb_isram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/isram.sv
// isram: instruction fetch responder that serves one request at a time from a small ROM after a fixed latency.
// Defining ISRAM_RAND_DELAY_EN replaces LATENCY with a per-request pseudo-random delay of 1..8 cycles.
module isram #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MEM_WORDS = 16,
  parameter logic [MEM_WORDS*32-1:0] MEM_INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  // MEM_WORDS must be a power of two; the word index wraps within the ROM.
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] pmem_reads_q, pmem_reads_d;
  logic [31:0] rom [MEM_WORDS];
  logic [3:0]  txn_lat;
  logic [31:0] rd_addr;
  logic        enter_resp;
  logic        unused_addr_bits;

  for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_rom
    assign rom[gi] = MEM_INIT[gi*32 +: 32];
  end

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       unused_latency;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign txn_lat        = 4'd1 + {1'b0, lfsr_q[2:0]};
  assign unused_latency = ^4'(LATENCY);
`else
  assign txn_lat = 4'(LATENCY);
`endif

  function automatic logic [31:0] n_pmem_read(input logic [IDX_W-1:0] word_idx);
    return rom[word_idx];
  endfunction

  // A latency-1 request enters RESP on its accepting edge, before addr_q holds the address.
  assign rd_addr          = (state_q == S_IDLE) ? araddr : addr_q;
  assign unused_addr_bits = ^rd_addr[31:IDX_W+2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    pmem_reads_d = pmem_reads_q;
    enter_resp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          addr_d = araddr;
          cnt_d  = txn_lat - 4'd1;
          if (txn_lat <= 4'd1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      if (rd_addr[1:0] != 2'b00) begin
        rdata_d = 32'h0;
        rresp_d = 2'b10;
      end else begin
        rdata_d      = n_pmem_read(rd_addr[IDX_W+1:2]);
        rresp_d      = 2'b00;
        pmem_reads_d = pmem_reads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      rdata_q      <= 32'h0;
      rresp_q      <= 2'b00;
      pmem_reads_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      pmem_reads_q <= pmem_reads_d;
    end
  end

  assign arready = (state_q == S_IDLE) && !rst;
  assign rvalid  = (state_q == S_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_isram.sv
// Bench for isram: three instances (latency 1, 3, 4) driven by directed and random fetches,
// checked against a word-array memory model and per-request latency expectations.
module tb_isram;
  localparam logic [16*32-1:0] IMG = {
    32'hFEED_FACE, 32'h0000_8067, 32'h00B5_0533, 32'h0041_2083,
    32'h00C1_0113, 32'hFE01_0113, 32'h0051_2023, 32'h4000_0537,
    32'h0010_0093, 32'h0020_0113, 32'h0031_81B3, 32'h1234_5678,
    32'hDEAD_BEEF, 32'h0000_0013, 32'hCAFE_0001, 32'h0000_0413
  };

  logic        clk = 1'b0;
  logic        rst_s     [3];
  logic        arvalid_s [3];
  logic        arready_s [3];
  logic [31:0] araddr_s  [3];
  logic        rvalid_s  [3];
  logic        rready_s  [3];
  logic [31:0] rdata_s   [3];
  logic [1:0]  rresp_s   [3];
  logic [31:0] reads_s   [3];

  logic [16*32-1:0] img_v;
  int          exp_reads [3];
  int          last_acc  [3];
  int          last_lat  [3];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    isram #(
      .LATENCY  ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
      .MEM_WORDS(16),
      .MEM_INIT (IMG)
    ) u_dut (
      .clk    (clk),
      .rst    (rst_s[gi]),
      .arvalid(arvalid_s[gi]),
      .arready(arready_s[gi]),
      .araddr (araddr_s[gi]),
      .rvalid (rvalid_s[gi]),
      .rready (rready_s[gi]),
      .rdata  (rdata_s[gi]),
      .rresp  (rresp_s[gi])
    );
    assign reads_s[gi] = u_dut.pmem_reads_q;
  end

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_m [3];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) lfsr_m[k] <= rst_s[k] ? 8'hA5 : lfsr_step(lfsr_m[k]);
  end
`endif

  // Latency the next request on lane k should see if it is accepted at the coming edge.
  function automatic int exp_latency(input int k);
`ifdef ISRAM_RAND_DELAY_EN
    return 1 + int'(lfsr_m[k][2:0]);
`else
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One fetch on lane k; d = RESP cycles with rready low before the handshake.
  task automatic do_txn(input int k, input logic [31:0] addr, input int d, input bit b2b);
    int n;
    int acc;
    int lat_e;
    logic [31:0] data_e;
    logic [1:0]  resp_e;
    arvalid_s[k] = 1'b1;
    araddr_s[k]  = addr;
    rready_s[k]  = (d == 0);
    n = 0;
    while (arready_s[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", arready_s[k], 1'b1);
    acc   = cyc;
    lat_e = exp_latency(k);
    if (b2b) check("b2b_period", acc - last_acc[k], last_lat[k] + 1);
    @(negedge clk);
    arvalid_s[k] = 1'b0;
    araddr_s[k]  = $urandom;
    n = 1;
    while (rvalid_s[k] !== 1'b1 && n < 40) begin
      check("wait_arready", arready_s[k], 1'b0);
      @(negedge clk);
      n++;
    end
    check("latency", n, lat_e);
`ifdef ISRAM_RAND_DELAY_EN
    check("lat_range", (n >= 1 && n <= 8), 1'b1);
`endif
    if (addr[1:0] != 2'b00) begin
      data_e = 32'h0;
      resp_e = 2'b10;
    end else begin
      data_e = img_v[addr[5:2]*32 +: 32];
      resp_e = 2'b00;
      exp_reads[k]++;
    end
    check("rdata", rdata_s[k], data_e);
    check("rresp", rresp_s[k], resp_e);
    check("resp_arready", arready_s[k], 1'b0);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      check("hold_rvalid", rvalid_s[k], 1'b1);
      check("hold_rdata", rdata_s[k], data_e);
      check("hold_rresp", rresp_s[k], resp_e);
      check("hold_arready", arready_s[k], 1'b0);
    end
    rready_s[k] = 1'b1;
    @(negedge clk);
    check("done_rvalid", rvalid_s[k], 1'b0);
    check("done_arready", arready_s[k], 1'b1);
    check("pmem_reads", reads_s[k], exp_reads[k]);
    rready_s[k] = 1'b0;
    last_acc[k] = acc;
    last_lat[k] = lat_e;
    $display("txn lane=%0d addr=%h acc_cyc=%0d lat=%0d hold=%0d rdata=%h rresp=%b",
             k, addr, acc, n, d, data_e, resp_e);
  endtask

  // Accept a request, then pulse reset during the first WAIT cycle.
  task automatic reset_midwait(input int k);
    int n;
    arvalid_s[k] = 1'b1;
    araddr_s[k]  = 32'h8000_0004;
    rready_s[k]  = 1'b1;
    n = 0;
    while (arready_s[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_accept", arready_s[k], 1'b1);
    @(negedge clk);
    arvalid_s[k] = 1'b0;
    rst_s[k]     = 1'b1;
    #1;
    check("rst_arready0", arready_s[k], 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_arready", arready_s[k], 1'b0);
      check("rst_rvalid", rvalid_s[k], 1'b0);
      check("rst_rdata", rdata_s[k], 32'h0);
    end
    rst_s[k]     = 1'b0;
    exp_reads[k] = 0;
    #1;
    check("rst_release_arready", arready_s[k], 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_no_rvalid", rvalid_s[k], 1'b0);
    end
    check("rst_no_read", reads_s[k], exp_reads[k]);
    $display("txn lane=%0d reset abandoned request at cyc=%0d", k, cyc);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    img_v = IMG;
    for (int k = 0; k < 3; k++) begin
      rst_s[k]     = 1'b1;
      arvalid_s[k] = 1'b0;
      araddr_s[k]  = 32'h0;
      rready_s[k]  = 1'b0;
      exp_reads[k] = 0;
      last_acc[k]  = 0;
      last_lat[k]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_arready", arready_s[k], 1'b0);
      check("reset_rvalid", rvalid_s[k], 1'b0);
      check("reset_rdata", rdata_s[k], 32'h0);
      check("reset_rresp", rresp_s[k], 2'b00);
      rst_s[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) check("post_reset_arready", arready_s[k], 1'b1);
    @(negedge clk);

    do_txn(0, 32'h8000_0000, 0, 1'b0);
    do_txn(1, 32'h8000_0008, 3, 1'b0);
    do_txn(0, 32'h8000_0002, 0, 1'b0);
    do_txn(2, 32'h8000_0003, 2, 1'b0);
    do_txn(1, 32'hFFFF_FFFC, 1, 1'b0);
    reset_midwait(2);

    for (int i = 0; i < 100; i++) do_txn(1, rand_addr(), 0, (i != 0));

    for (int i = 0; i < 50; i++) begin
      int k;
      k = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(k, rand_addr(), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
